// File: rtl/dct_cos_mac_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dct_cos_mac_engine : buffers one frame, MACs it against the cosine ROM and
// streams N_COEF coefficients. Option macro DCT_ROUND_EN: round half up.
// Rev 1.0
// ---------------------------------------------------------------------------
module dct_cos_mac_engine #(
  parameter int N_PTS  = 32,
  parameter int N_COEF = 16,
  parameter int DIN_W  = 16,
  parameter int COS_W  = 9,
  parameter int ADDR_W = 9,
  parameter int FRAC   = 7,
  parameter int DOUT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DIN_W-1:0]   s_data,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic signed [COS_W-1:0]   rom_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [DOUT_W-1:0]  m_data,
  output logic [$clog2(N_COEF)-1:0] m_index,
  output logic                      m_last,
  output logic                      busy
);
  localparam int N_W    = $clog2(N_PTS);
  localparam int K_W    = $clog2(N_COEF);
  localparam int PROD_W = DIN_W + COS_W;
  localparam int ACC_W  = PROD_W + N_W;
  localparam int FIN_W  = ACC_W + 1;
  localparam logic [N_W-1:0] N_LAST = N_W'(N_PTS - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_COEF - 1);
  localparam logic signed [FIN_W-1:0] SAT_MAX = FIN_W'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [FIN_W-1:0] SAT_MIN = FIN_W'(-(1 << (DOUT_W - 1)));
`ifdef DCT_ROUND_EN
  localparam logic signed [FIN_W-1:0] RND = FIN_W'(1 << (FRAC - 1));
`else
  localparam logic signed [FIN_W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {ST_LOAD, ST_CALC, ST_DRAIN, ST_OUT} state_t;

  state_t                    state_q, state_d;
  logic [N_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [N_W-1:0]            n_q, n_d;
  logic [K_W-1:0]            k_q, k_d;
  logic signed [PROD_W-1:0]  prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]         last_addr_q, last_addr_d;
  logic                      m_valid_q, m_valid_d;
  logic signed [DOUT_W-1:0]  m_data_q, m_data_d;
  logic [K_W-1:0]            m_index_q, m_index_d;
  logic                      m_last_q, m_last_d;

  logic signed [DIN_W-1:0]   samp_q [N_PTS];
  logic                      samp_we;
  logic signed [DIN_W-1:0]   rd_sample;
  logic signed [FIN_W-1:0]   acc_fin;
  logic signed [FIN_W-1:0]   acc_shr;

  assign rd_sample = samp_q[n_q];
  // Final sum folds in the product still sitting in the pipeline register.
  assign acc_fin   = FIN_W'(acc_q) + FIN_W'(prod_q) + RND;
  assign acc_shr   = acc_fin >>> FRAC;

  assign s_ready  = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_LOAD);
  assign rom_addr = (state_q == ST_CALC) ? {k_q, n_q} : last_addr_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_index  = m_index_q;
  assign m_last   = m_last_q;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    n_d         = n_q;
    k_d         = k_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    last_addr_d = last_addr_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_index_d   = m_index_q;
    m_last_d    = m_last_q;
    samp_we     = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          samp_we = 1'b1;
          if (wr_cnt_q == N_LAST) begin
            wr_cnt_d = '0;
            k_d      = '0;
            n_d      = '0;
            state_d  = ST_CALC;
          end else begin
            wr_cnt_d = wr_cnt_q + N_W'(1);
          end
        end
      end
      ST_CALC: begin
        prod_d      = PROD_W'(rd_sample) * PROD_W'(rom_data);
        acc_d       = (n_q == '0) ? '0 : acc_q + ACC_W'(prod_q);
        last_addr_d = {k_q, n_q};
        // n parks on its last value so rom_addr never wraps into the next row
        if (n_q == N_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          n_d = n_q + N_W'(1);
        end
      end
      ST_DRAIN: begin
        if (acc_shr > SAT_MAX) begin
          m_data_d = DOUT_W'(SAT_MAX);
        end else if (acc_shr < SAT_MIN) begin
          m_data_d = DOUT_W'(SAT_MIN);
        end else begin
          m_data_d = DOUT_W'(acc_shr);
        end
        m_valid_d = 1'b1;
        m_index_d = k_q;
        m_last_d  = (k_q == K_LAST);
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            k_d     = '0;
            state_d = ST_LOAD;
          end else begin
            k_d     = k_q + K_W'(1);
            n_d     = '0;
            state_d = ST_CALC;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_cnt_q    <= '0;
      n_q         <= '0;
      k_q         <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      last_addr_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_index_q   <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      n_q         <= n_d;
      k_q         <= k_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      last_addr_q <= last_addr_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_index_q   <= m_index_d;
      m_last_q    <= m_last_d;
    end
  end

  // Sample store has no reset: every entry is rewritten before a frame is used.
  always_ff @(posedge clk) begin
    if (samp_we) begin
      samp_q[wr_cnt_q] <= s_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_cos_mac_engine.sv
`default_nettype none
// tb_dct_cos_mac_engine: random and directed frames checked against a direct
// floor(sum(x*c)/2**FRAC) reference with saturation.
module tb_dct_cos_mac_engine;
  localparam int N_PTS  = 32;
  localparam int N_COEF = 16;
  localparam int DIN_W  = 16;
  localparam int COS_W  = 9;
  localparam int ADDR_W = 9;
  localparam int FRAC   = 7;
  localparam int DOUT_W = 16;

  logic                     clk     = 1'b0;
  logic                     rst_n   = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     m_ready = 1'b1;
  logic signed [DIN_W-1:0]  s_data  = '0;
  logic                     s_ready;
  logic [ADDR_W-1:0]        rom_addr;
  logic signed [COS_W-1:0]  rom_data;
  logic                     m_valid;
  logic signed [DOUT_W-1:0] m_data;
  logic [3:0]               m_index;
  logic                     m_last;
  logic                     busy;

  int     samp    [N_PTS];
  int     rom_tbl [N_PTS*N_COEF];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  longint ref_cyc  = 0;
  bit     mon_en   = 1'b0;
  int     addr_log [$];

  dct_cos_mac_engine #(
    .N_PTS(N_PTS), .N_COEF(N_COEF), .DIN_W(DIN_W), .COS_W(COS_W),
    .ADDR_W(ADDR_W), .FRAC(FRAC), .DOUT_W(DOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data = COS_W'(rom_tbl[rom_addr]);

  always @(negedge clk) begin
    if (mon_en && busy && !m_valid) begin
      if (addr_log.size() == 0 || addr_log[addr_log.size()-1] != int'(rom_addr))
        addr_log.push_back(int'(rom_addr));
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Exact dot product, optional +half, floor division, clamp.
  function automatic longint model_coef(int k);
    longint acc = 0;
    longint q;
    for (int n = 0; n < N_PTS; n++)
      acc += longint'(samp[n]) * longint'(rom_tbl[k*N_PTS + n]);
`ifdef DCT_ROUND_EN
    acc += longint'(2 ** (FRAC - 1));
`endif
    q = acc / longint'(2 ** FRAC);
    if ((acc % longint'(2 ** FRAC)) != 0 && acc < 0) q -= 1;
    if (q > longint'(2 ** (DOUT_W - 1) - 1)) q = longint'(2 ** (DOUT_W - 1) - 1);
    if (q < -longint'(2 ** (DOUT_W - 1)))    q = -longint'(2 ** (DOUT_W - 1));
    return q;
  endfunction

  task automatic fill_cos();
    for (int k = 0; k < N_COEF; k++)
      for (int n = 0; n < N_PTS; n++)
        rom_tbl[k*N_PTS + n] = int'(127.0 * $cos(3.14159265358979 * real'((2*n + 1) * k) / real'(2*N_PTS)));
  endtask

  task automatic fill_rom_const(input int v);
    for (int i = 0; i < N_PTS*N_COEF; i++) rom_tbl[i] = v;
  endtask

  task automatic fill_rom_rand();
    for (int i = 0; i < N_PTS*N_COEF; i++) rom_tbl[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic fill_samp_const(input int v);
    for (int i = 0; i < N_PTS; i++) samp[i] = v;
  endtask

  task automatic fill_samp_rand();
    for (int i = 0; i < N_PTS; i++) samp[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // mode 0: continuous valid, 1: toggle 1/0, 2: random gaps
  task automatic send_frame(input int mode);
    int i     = 0;
    int guard = 0;
    bit tog   = 1'b1;
    while (i < N_PTS && guard < 1000) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = tog; tog = !tog; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = DIN_W'(samp[i]);
      if (s_valid && s_ready) begin
        i++;
        if (i == N_PTS) ref_cyc = cyc + 1;
      end
    end
    if (i < N_PTS) check_eq("load_timeout", i, N_PTS);
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("calc_start_busy", busy, 1);
    check_eq("calc_start_sready", s_ready, 0);
  endtask

  task automatic recv_frame(input int stall_k, input bit rnd_ready);
    int     guard;
    longint hold_data;
    longint hold_idx;
    longint hold_addr;
    for (int k = 0; k < N_COEF; k++) begin
      guard = 0;
      while (!m_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!m_valid) begin
        check_eq("out_timeout", 0, 1);
        m_ready = 1'b1;
        return;
      end
      check_eq("latency", cyc - ref_cyc, N_PTS + 1);
      check_eq("m_data", m_data, model_coef(k));
      check_eq("m_index", m_index, k);
      check_eq("m_last", m_last, longint'(k == N_COEF - 1));
      hold_data = m_data;
      hold_idx  = m_index;
      hold_addr = rom_addr;
      if (k == stall_k) begin
        m_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check_eq("stall_valid", m_valid, 1);
          check_eq("stall_data", m_data, hold_data);
          check_eq("stall_index", m_index, hold_idx);
          check_eq("stall_addr", rom_addr, hold_addr);
          check_eq("stall_sready", s_ready, 0);
          check_eq("stall_busy", busy, 1);
        end
      end else if (rnd_ready) begin
        m_ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          check_eq("rstall_data", m_data, hold_data);
        end
      end
      m_ready = 1'b1;
      ref_cyc = cyc + 1;
      @(negedge clk);
      check_eq("valid_drop", m_valid, 0);
    end
    check_eq("sready_after", s_ready, 1);
    check_eq("busy_after", busy, 0);
  endtask

  initial begin
    int errs;
    int guard;
    fill_samp_const(0);
    fill_rom_const(0);
    repeat (3) @(negedge clk);
    check_eq("rst_sready", s_ready, 1);
    check_eq("rst_mvalid", m_valid, 0);
    check_eq("rst_mdata", m_data, 0);
    check_eq("rst_mindex", m_index, 0);
    check_eq("rst_mlast", m_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", rom_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero frame against the cosine table
    fill_cos();
    send_frame(0);
    recv_frame(-1, 1'b0);

    // Impulse of 128 picks out column 0 of each row; watch the address sweep
    fill_samp_const(0);
    samp[0] = 128;
    addr_log.delete();
    mon_en = 1'b1;
    send_frame(0);
    recv_frame(-1, 1'b0);
    mon_en = 1'b0;
    check_eq("sweep_len", addr_log.size(), N_PTS*N_COEF);
    errs = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) errs++;
    check_eq("sweep_order_errs", errs, 0);

    // Saturation both ways
    fill_rom_const(127);
    fill_samp_const(32767);
    send_frame(0);
    recv_frame(-1, 1'b0);
    fill_samp_const(-32768);
    send_frame(0);
    recv_frame(-1, 1'b0);

    // Rounding boundary: sample 1 against cosine 64
    fill_samp_const(0);
    samp[0] = 1;
    fill_rom_const(64);
    send_frame(0);
    recv_frame(-1, 1'b0);

    // Toggling valid during load, 10-cycle stall on coefficient 3
    fill_cos();
    fill_samp_rand();
    send_frame(1);
    recv_frame(3, 1'b0);

    // Random frames, random gaps and back-pressure
    for (int f = 0; f < 4; f++) begin
      fill_rom_rand();
      fill_samp_rand();
      send_frame(2);
      recv_frame(-1, 1'b1);
    end

    // Reset mid-CALC at k=5, n=10
    fill_samp_rand();
    send_frame(0);
    guard = 0;
    while (!(busy && !m_valid && rom_addr == ADDR_W'(5*N_PTS + 10)) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reach_k5n10", rom_addr, 5*N_PTS + 10);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_mvalid", m_valid, 0);
    check_eq("mrst_sready", s_ready, 1);
    check_eq("mrst_addr", rom_addr, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_mdata", m_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_samp_rand();
    send_frame(2);
    recv_frame(-1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
